// File: rtl/ecc_apb_engine.sv
// ecc_apb_engine
// APB-attached SECDED (extended Hamming) encode/decode engine. The codeword
// width is selected at runtime (8, 16 or 32 bits). Software programs DATA_IN,
// NOISE and CW_WIDTH, then launches ENCODE, DECODE or FULL (encode, add
// noise, decode) by writing CTRL. Each completed result is presented on
// data_out/num_of_errors with a one-cycle operation_done pulse. It is also
// queued for readback through the RESULT register.
//
// Build option: define ECC_RESULT_FIFO_EN for a FIFO_DEPTH-entry result FIFO.
// Without it, a single overwrite-on-push result register is used.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   PADDR/PWDATA    APB address (only [4:0] decoded) and write data
//   PSEL/PENABLE/PWRITE  APB control (zero wait states)
//   PRDATA          read data, registered from the setup phase
//   data_out        result of the completing operation (zero-extended)
//   operation_done  one-cycle completion pulse
//   num_of_errors   error count of the completing operation
module ecc_apb_engine #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors
);

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_DATA   = 5'h04;
  localparam logic [4:0] A_CW     = 5'h08;
  localparam logic [4:0] A_NOISE  = 5'h0C;
  localparam logic [4:0] A_STATUS = 5'h10;
  localparam logic [4:0] A_RESULT = 5'h14;

  localparam logic [1:0] OP_DEC  = 2'd1;
  localparam logic [1:0] OP_FULL = 2'd2;
  localparam logic [1:0] OP_NOP  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_DEC, S_OUT} state_t;

  function automatic int cw_len(input logic [1:0] wsel);
    case (wsel)
      2'd0:    return 8;
      2'd1:    return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] cw_mask(input logic [1:0] wsel);
    case (wsel)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order; parity
  // bit 2^b covers every data position whose index has bit b set.
  function automatic logic [31:0] ecc_encode(input logic [31:0] d, input logic [1:0] wsel);
    logic [31:0] cw;
    logic        par;
    int          n;
    int          j;
    n  = cw_len(wsel);
    cw = '0;
    j  = 0;
    for (int i = 1; i < 32; i++) begin
      if (i < n && (i & (i - 1)) != 0) begin
        cw[i] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      par = 1'b0;
      for (int i = 1; i < 32; i++) begin
        if ((i & (i - 1)) != 0 && i[b]) par ^= cw[i];
      end
      if ((1 << b) < n) cw[1 << b] = par;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  // Returns {num_of_errors, data}. The syndrome always stays below n because
  // n is a power of two, so the correcting flip never leaves the codeword.
  function automatic logic [33:0] ecc_decode(input logic [31:0] c_in, input logic [1:0] wsel);
    logic [31:0] c;
    logic [31:0] d;
    logic [4:0]  syn;
    logic        p;
    logic [1:0]  err;
    int          n;
    int          j;
    c   = c_in & cw_mask(wsel);
    n   = cw_len(wsel);
    syn = '0;
    d   = '0;
    j   = 0;
    p   = ^c;
    for (int i = 1; i < 32; i++) begin
      if (c[i]) syn ^= i[4:0];
    end
    if (p) begin
      c[syn] = ~c[syn];
      err    = 2'd1;
    end else if (syn != 5'd0) begin
      err = 2'd2;
    end else begin
      err = 2'd0;
    end
    for (int i = 1; i < 32; i++) begin
      if (i < n && (i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return {err, d};
  endfunction

  state_t      state, state_nx;
  logic [4:0]  addr;
  logic        access, wr_en, rd_setup, wr_ctrl, launch;
  logic        push, pop, full, empty, ovf_set;
  logic [1:0]  ctrl_q, cw_width_q;
  logic [31:0] data_in_q, noise_q;
  logic        ovf_q, berr_q, rd_ok_q;
  logic [3:0]  count_q;
  logic [33:0] head;
  logic [31:0] status, rd_mux;
  logic [1:0]  op_p0, wsel_p0;
  logic [31:0] data_p0, noise_p0;
  logic [31:0] cw_p1;
  logic [33:0] dec_res, res_p2;
  logic        unused_addr;

  assign addr        = PADDR[4:0];
  assign unused_addr = ^PADDR[AMBA_ADDR_WIDTH-1:5];
  assign access      = PSEL & PENABLE;
  assign wr_en       = access & PWRITE;
  assign rd_setup    = PSEL & ~PENABLE & ~PWRITE;
  assign wr_ctrl     = wr_en & (addr == A_CTRL);
  assign launch      = wr_ctrl & (state == S_IDLE) & (PWDATA[1:0] != OP_NOP);
  assign push        = (state == S_OUT);
  // Only pop if the setup phase saw a valid head, so a push landing between
  // setup and access never gets silently consumed.
  assign pop         = access & ~PWRITE & (addr == A_RESULT) & rd_ok_q;
  assign empty       = (count_q == 4'd0);
  assign ovf_set     = push & full & ~pop;

  assign operation_done = (state == S_OUT);
  assign data_out       = DATA_WIDTH'(res_p2[31:0]);
  assign num_of_errors  = res_p2[33:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (launch) state_nx = S_ENC;
      S_ENC:   state_nx = S_DEC;
      S_DEC:   state_nx = S_OUT;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      data_in_q  <= '0;
      cw_width_q <= '0;
      noise_q    <= '0;
    end else if (wr_en) begin
      case (addr)
        A_CTRL:  if (state == S_IDLE) ctrl_q <= PWDATA[1:0];
        A_DATA:  data_in_q  <= PWDATA[31:0];
        A_CW:    cw_width_q <= PWDATA[1:0];
        A_NOISE: noise_q    <= PWDATA[31:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      if (wr_en && addr == A_STATUS) begin
        ovf_q  <= 1'b0;
        berr_q <= 1'b0;
      end
      if (wr_ctrl && state != S_IDLE) berr_q <= 1'b1;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // Stage p0: operand snapshot at launch
  always_ff @(posedge clk) begin
    if (launch) begin
      op_p0    <= PWDATA[1:0];
      wsel_p0  <= cw_width_q;
      data_p0  <= data_in_q;
      noise_p0 <= noise_q;
    end
  end

  // Stage p1: encode (DECODE passes the input codeword through)
  always_ff @(posedge clk) begin
    if (state == S_ENC) begin
      cw_p1 <= (op_p0 == OP_DEC) ? (data_p0 & cw_mask(wsel_p0))
                                 : ecc_encode(data_p0, wsel_p0);
    end
  end

  always_comb begin
    dec_res = {2'b00, cw_p1};
    case (op_p0)
      OP_DEC:  dec_res = ecc_decode(cw_p1, wsel_p0);
      OP_FULL: dec_res = ecc_decode(cw_p1 ^ (noise_p0 & cw_mask(wsel_p0)), wsel_p0);
      default: ;
    endcase
  end

  // Stage p2: noise/decode result, held on the outputs until the next OUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 res_p2 <= '0;
    else if (state == S_DEC) res_p2 <= dec_res;
  end

`ifdef ECC_RESULT_FIFO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  logic [33:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push_ok;

  assign full    = (count_q == 4'(FIFO_DEPTH));
  assign push_ok = push & (~full | pop);
  assign head    = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= res_p2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)     rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: ;
      endcase
    end
  end
`else
  logic [33:0] slot_q;

  assign full = (count_q != 4'd0);
  assign head = slot_q;

  always_ff @(posedge clk) begin
    if (push) slot_q <= res_p2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count_q <= '0;
    else if (push) count_q <= 4'd1;
    else if (pop)  count_q <= 4'd0;
  end
`endif

  always_comb begin
    status        = '0;
    status[1:0]   = empty ? 2'b00 : head[33:32];
    status[2]     = empty;
    status[3]     = full;
    status[4]     = (state != S_IDLE);
    status[5]     = ovf_q;
    status[6]     = berr_q;
    status[11:8]  = count_q;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:   rd_mux[1:0] = ctrl_q;
      A_DATA:   rd_mux      = data_in_q;
      A_CW:     rd_mux[1:0] = cw_width_q;
      A_NOISE:  rd_mux      = noise_q;
      A_STATUS: rd_mux      = status;
      A_RESULT: rd_mux      = empty ? 32'h0 : head[31:0];
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PRDATA  <= '0;
      rd_ok_q <= 1'b0;
    end else if (rd_setup) begin
      PRDATA  <= AMBA_WORD'(rd_mux);
      rd_ok_q <= (addr == A_RESULT) & ~empty;
    end
  end

endmodule

// File: tb/tb_ecc_apb_engine.sv
module tb_ecc_apb_engine;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int FD = 4;
`ifdef ECC_RESULT_FIFO_EN
  localparam int MD = FD;
  localparam bit FIFO_ON = 1'b1;
`else
  localparam int MD = 1;
  localparam bit FIFO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PSEL, PENABLE, PWRITE;
  logic [31:0]   PRDATA;
  logic [DW-1:0] data_out;
  logic          operation_done;
  logic [1:0]    num_of_errors;

  ecc_apb_engine #(
    .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(32), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PRDATA(PRDATA), .data_out(data_out),
    .operation_done(operation_done), .num_of_errors(num_of_errors)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int pulses = 0;
  logic [33:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_berr = 1'b0;

  always @(negedge clk) if (operation_done === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int nlen(input int w);
    return (w == 0) ? 8 : (w == 1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] mmask(input int n);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  function automatic bit is_par(input int i);
    return (i == 1 || i == 2 || i == 4 || i == 8 || i == 16);
  endfunction

  // Parity bits equal the XOR of the indices of all set data positions,
  // which makes the syndrome of the finished codeword zero.
  function automatic logic [31:0] m_enc(input logic [31:0] d, input int n);
    logic [31:0] c;
    logic [4:0]  s;
    int          j;
    c = '0; s = '0; j = 0;
    for (int i = 1; i < n; i++) begin
      if (!is_par(i)) begin
        c[i] = d[j];
        if (d[j]) s ^= 5'(i);
        j++;
      end
    end
    for (int b = 0; b < 5; b++) if ((1 << b) < n) c[1 << b] = s[b];
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] c, input int n);
    logic [31:0] d;
    int          j;
    d = '0; j = 0;
    for (int i = 1; i < n; i++) begin
      if (!is_par(i)) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  // Nearest-codeword decode: valid as is, valid after one flip, else double.
  function automatic logic [33:0] m_result(input int op, input logic [31:0] din,
                                           input logic [31:0] nz, input int w);
    int          n;
    logic [31:0] c, x;
    n = nlen(w);
    if (op == 0) return {2'd0, m_enc(din, n)};
    c = (op == 1) ? (din & mmask(n)) : (m_enc(din, n) ^ (nz & mmask(n)));
    if (m_enc(m_ext(c, n), n) == c) return {2'd0, m_ext(c, n)};
    for (int i = 0; i < n; i++) begin
      x = c;
      x[i] = ~x[i];
      if (m_enc(m_ext(x, n), n) == x) return {2'd1, m_ext(x, n)};
    end
    return {2'd2, m_ext(c, n)};
  endfunction

  task automatic model_push(input logic [33:0] r);
    if (mq.size() < MD) mq.push_back(r);
    else begin
      m_ovf = 1'b1;
      if (!FIFO_ON) mq[0] = r;
    end
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    logic [31:0] s;
    int          c;
    c = mq.size();
    s = '0;
    s[1:0]  = (c == 0) ? 2'b00 : mq[0][33:32];
    s[2]    = (c == 0);
    s[3]    = (c == MD);
    s[4]    = busy;
    s[5]    = m_ovf;
    s[6]    = m_berr;
    s[11:8] = 4'(c);
    return s;
  endfunction

  // ---------------- APB helpers ----------------
  task automatic apb_setup(input logic [4:0] a, input logic [31:0] d, input bit wr);
    PADDR   = AW'({15'($urandom()), a});
    PWDATA  = d;
    PWRITE  = wr;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
  endtask

  task automatic apb_idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
    apb_setup(a, d, 1'b1);
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 apb_idle();
  endtask

  task automatic apb_rd(input logic [4:0] a, output logic [31:0] d);
    apb_setup(a, 32'h0, 1'b0);
    @(posedge clk); #1 PENABLE = 1'b1;
    d = PRDATA;
    @(posedge clk); #1 apb_idle();
  endtask

  task automatic rd_result();
    logic [31:0] v, e;
    e = (mq.size() != 0) ? mq.pop_front()[31:0] : 32'h0;
    apb_rd(5'h14, v);
    chk("result_rd", v, e);
  endtask

  task automatic rd_status(input bit busy);
    logic [31:0] v;
    apb_rd(5'h10, v);
    chk("status_rd", v, exp_status(busy));
  endtask

  task automatic load(input logic [31:0] din, input logic [31:0] nz, input int w);
    apb_wr(5'h08, 32'(w));
    apb_wr(5'h04, din);
    apb_wr(5'h0C, nz);
  endtask

  task automatic run_op(input int op, input logic [31:0] din, input logic [31:0] nz, input int w);
    logic [33:0] r;
    r = m_result(op, din, nz, w);
    load(din, nz, w);
    apb_wr(5'h00, 32'(op));
    chk("done_T1", operation_done, 1'b0);
    @(posedge clk); #1 chk("done_T2", operation_done, 1'b0);
    @(posedge clk); #1 chk("done_T3", operation_done, 1'b1);
    chk("data_out", data_out, DW'(r[31:0]));
    chk("num_err", num_of_errors, r[33:32]);
    model_push(r);
    @(posedge clk); #1 chk("done_T4", operation_done, 1'b0);
  endtask

  function automatic logic [31:0] err_vec(input int n);
    logic [31:0] e;
    int          wt, i1, i2;
    e  = '0;
    wt = $urandom_range(0, 2);
    i1 = $urandom_range(0, n - 1);
    i2 = (i1 + 1 + $urandom_range(0, n - 2)) % n;
    if (wt >= 1) e[i1] = 1'b1;
    if (wt == 2) e[i2] = 1'b1;
    return e;
  endfunction

  initial begin
    logic [31:0] v, din, nz, junk;
    logic [33:0] ra, rb;
    int          op, w, n, p0;

    rst = 1'b1;
    PADDR = '0; PWDATA = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_done", operation_done, 1'b0);
    chk("rst_nerr", num_of_errors, 2'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_status(1'b0);
    for (int a = 0; a < 4; a++) begin
      apb_rd(5'(a * 4), v);
      chk("rst_reg", v, 32'h0);
    end

    // Directed examples at n = 8
    run_op(0, 32'hB, 32'h0, 0);
    chk("enc_B", data_out, 32'hAA);
    rd_result();
    rd_status(1'b0);
    run_op(1, 32'hAA, 32'h0, 0);
    chk("dec_AA", {num_of_errors, data_out}, {2'd0, 32'hB});
    rd_result();
    run_op(1, 32'hA2, 32'h0, 0);
    chk("dec_A2", {num_of_errors, data_out}, {2'd1, 32'hB});
    rd_result();
    run_op(2, 32'hB, 32'h08, 0);
    chk("full_n08", {num_of_errors, data_out}, {2'd1, 32'hB});
    rd_result();
    run_op(2, 32'hB, 32'h0C, 0);
    chk("full_n0C", {num_of_errors, data_out}, {2'd2, 32'hA});
    rd_result();
    rd_result();

    // Unmapped address and no-op CTRL
    apb_wr(5'h18, 32'hDEAD_BEEF);
    apb_rd(5'h18, v);
    chk("unmapped", v, 32'h0);
    p0 = pulses;
    apb_wr(5'h00, 32'h3);
    repeat (4) @(posedge clk);
    #1 chk("nop_pulses", 32'(pulses - p0), 32'd0);
    apb_rd(5'h00, v);
    chk("nop_stored", v, 32'h3);

    // Overflow: five launches without reads
    for (int i = 0; i < 5; i++) run_op(0, $urandom(), 32'h0, $urandom_range(0, 3));
    rd_status(1'b0);
    while (mq.size() != 0) rd_result();
    rd_result();
    apb_wr(5'h10, 32'h0);
    m_ovf = 1'b0;
    rd_status(1'b0);

    // Push and pop in the same cycle while full
    for (int i = 0; i < MD; i++) run_op(0, $urandom(), 32'h0, $urandom_range(0, 3));
    din = $urandom();
    w   = $urandom_range(0, 3);
    ra  = m_result(0, din, 32'h0, w);
    load(din, 32'h0, w);
    apb_wr(5'h00, 32'h0);
    @(posedge clk); #1 apb_setup(5'h14, 32'h0, 1'b0);
    @(posedge clk); #1 PENABLE = 1'b1;
    v = PRDATA;
    chk("pp_done", operation_done, 1'b1);
    chk("pp_pop", v, mq.pop_front()[31:0]);
    model_push(ra);
    @(posedge clk); #1 apb_idle();
    rd_status(1'b0);
    while (mq.size() != 0) rd_result();

    // Back-to-back: next launch's access phase in cycle T+4
    din = $urandom();
    nz  = 32'h1 << $urandom_range(0, 7);
    ra  = m_result(0, din, nz, 0);
    rb  = m_result(2, din, nz, 0);
    load(din, nz, 0);
    apb_wr(5'h00, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 chk("b2b_doneA", {num_of_errors, data_out}, {ra[33:32], ra[31:0]});
    model_push(ra);
    apb_setup(5'h00, 32'h2, 1'b1);
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 apb_idle();
    @(posedge clk); #1;
    @(posedge clk); #1 chk("b2b_doneB", operation_done, 1'b1);
    chk("b2b_resB", {num_of_errors, data_out}, {rb[33:32], rb[31:0]});
    model_push(rb);
    @(posedge clk); #1 rd_status(1'b0);
    while (mq.size() != 0) rd_result();

    // CTRL write while busy
    din = $urandom();
    ra  = m_result(0, din, 32'h0, 1);
    load(din, 32'h0, 1);
    apb_wr(5'h00, 32'h0);
    p0 = pulses;
    apb_wr(5'h00, 32'h2);
    chk("berr_done", operation_done, 1'b1);
    chk("berr_data", data_out, DW'(ra[31:0]));
    model_push(ra);
    m_berr = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("berr_pulses", 32'(pulses - p0), 32'd1);
    apb_rd(5'h00, v);
    chk("berr_ctrl", v, 32'h0);
    rd_status(1'b0);
    apb_wr(5'h10, 32'h0);
    m_berr = 1'b0;
    m_ovf  = 1'b0;
    rd_status(1'b0);
    while (mq.size() != 0) rd_result();

    // Randomized operations at all widths
    for (int it = 0; it < 24; it++) begin
      op   = $urandom_range(0, 2);
      w    = $urandom_range(0, 3);
      n    = nlen(w);
      junk = $urandom() & ~mmask(n);
      nz   = 32'h0;
      if (op == 0) din = $urandom();
      else if (op == 1) din = (m_enc($urandom(), n) ^ err_vec(n)) | junk;
      else begin
        din = $urandom();
        nz  = err_vec(n) | junk;
      end
      run_op(op, din, nz, w);
      if ($urandom_range(0, 1) == 1) rd_result();
      rd_status(1'b0);
    end

    // Reset in the middle of an operation
    run_op(0, 32'h5, 32'h0, 0);
    load(32'h7, 32'h0, 2);
    apb_wr(5'h00, 32'h0);
    p0 = pulses;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_out", {num_of_errors, data_out}, 34'h0);
    chk("mid_rst_done", operation_done, 1'b0);
    chk("mid_rst_prdata", PRDATA, 32'h0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_berr = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("mid_rst_pulses", 32'(pulses - p0), 32'd0);
    rd_status(1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
